mem_boot_loader: RTL and testbench

//  Single-master AHB-Lite writer that sits directly upstream of the on-chip SRAM slave.

---
 rtl/mem_loader_pkg.sv | 25 ++
 rtl/mem_loader_pack.sv | 56 +++++
 rtl/mem_boot_loader.sv | 165 ++++++++++++++++
 tb/tb_mem_boot_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared types and AHB-Lite constants for the boot loader that streams bytes into SRAM.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

  // Clears the low 'align' address bits so the base always lands on a word boundary.
  function automatic logic [31:0] align_addr(input logic [31:0] a, input int align);
    return a & ~((32'd1 << align) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_loader_pack.sv
// Packs little-endian bytes into a 32-bit word; holds the full word until acknowledged.
module mem_loader_pack
  import mem_loader_pkg::*;
(
  input  logic        hclk,
  input  logic        hrst_b,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        byte_rdy_o,
  output logic        word_vld_o,
  input  logic        word_ack_i,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        full_q, full_d;
  logic        take;

  assign byte_rdy_o = !full_q;
  assign take       = byte_vld_i && !full_q;
  // Valid already in the cycle the fourth byte arrives, so the caller can move on without a bubble.
  assign word_vld_o = full_q || (take && (cnt_q == 2'd3));
  assign word_o     = word_q;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    full_d = full_q;
    if (clr_i) begin
      cnt_d  = 2'd0;
      full_d = 1'b0;
    end else begin
      if (word_ack_i) full_d = 1'b0;
      if (take) begin
        word_d[{cnt_q, 3'b000} +: 8] = byte_i;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/mem_boot_loader.sv
// AHB-Lite single-word writer loading a byte-stream image into SRAM from a base address.
// Optional running checksum of accepted words: define MEM_LOADER_CSUM_EN.
module mem_boot_loader
  import mem_loader_pkg::*;
#(
  parameter int LEN_W      = 16,
  parameter int ADDR_ALIGN = 2
) (
  input  logic             hclk,
  input  logic             hrst_b,
  input  logic             start,
  input  logic [31:0]      cfg_base_addr,
  input  logic [LEN_W-1:0] cfg_len_words,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic [31:0]      haddr_m,
  output logic [1:0]       htrans_m,
  output logic             hwrite_m,
  output logic [2:0]       hsize_m,
  output logic [2:0]       hburst_m,
  output logic [3:0]       hprot_m,
  output logic             hsel_m,
  output logic [31:0]      hwdata_m,
  input  logic             hready_m,
  input  logic [1:0]       hresp_m,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      csum
);

  state_t           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;

  logic        start_acc, xfer_end, xfer_ok, last_word;
  logic        pk_rdy, pk_word_vld;
  logic [31:0] pk_word;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign xfer_end  = (state_q == ST_DATA) && hready_m;
  assign xfer_ok   = xfer_end && (hresp_m == HRESP_OKAY);
  assign last_word = (idx_q + LEN_W'(1)) == len_q;

  mem_loader_pack u_pack (
    .hclk       (hclk),
    .hrst_b     (hrst_b),
    .clr_i      (start_acc),
    .byte_vld_i (s_valid && (state_q == ST_FILL)),
    .byte_i     (s_data),
    .byte_rdy_o (pk_rdy),
    .word_vld_o (pk_word_vld),
    .word_ack_i (xfer_end),
    .word_o     (pk_word)
  );

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (cfg_len_words == '0) ? ST_DONE : ST_FILL;
      ST_FILL: if (pk_word_vld) state_d = ST_ADDR;
      ST_ADDR: if (hready_m) state_d = ST_DATA;
      ST_DATA: begin
        if (hready_m) begin
          if (hresp_m != HRESP_OKAY) state_d = ST_ERR;
          else if (last_word)        state_d = ST_DONE;
          else                       state_d = ST_FILL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready  = 1'b0;
    htrans_m = HTRANS_IDLE;
    hwrite_m = 1'b0;
    hsel_m   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_FILL: begin
        s_ready = pk_rdy;
        busy    = 1'b1;
      end
      ST_ADDR: begin
        htrans_m = HTRANS_NONSEQ;
        hwrite_m = 1'b1;
        hsel_m   = 1'b1;
        busy     = 1'b1;
      end
      ST_DATA: busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Job context is latched at start; the index advances only on an OKAY completion.
  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    idx_d  = idx_q;
    err_d  = err_q;
    if (start_acc) begin
      base_d = align_addr(cfg_base_addr, ADDR_ALIGN);
      len_d  = cfg_len_words;
      idx_d  = '0;
      err_d  = 1'b0;
    end else if (xfer_end) begin
      if (xfer_ok) idx_d = idx_q + LEN_W'(1);
      else         err_d = 1'b1;
    end
  end

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      base_q <= 32'd0;
      len_q  <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
    end
  end

  assign haddr_m  = base_q + (32'(idx_q) << 2);
  assign hwdata_m = pk_word;
  assign hsize_m  = HSIZE_WORD;
  assign hburst_m = HBURST_SINGLE;
  assign hprot_m  = HPROT_DATA;
  assign err      = err_q;

`ifdef MEM_LOADER_CSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_acc)    csum_d = 32'd0;
    else if (xfer_ok) csum_d = csum_q + pk_word;
  end

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) csum_q <= 32'd0;
    else         csum_q <= csum_d;
  end

  assign csum = csum_q;
`else
  assign csum = 32'd0;
`endif

endmodule

// File: tb/tb_mem_boot_loader.sv
// Bench for mem_boot_loader: directed table, reset corner cases and randomized jobs vs a word-level model.
`timescale 1ns/1ps
module tb_mem_boot_loader;
  localparam int LEN_W = 16;

  logic             hclk, hrst_b, start;
  logic [31:0]      cfg_base_addr;
  logic [LEN_W-1:0] cfg_len_words;
  logic             s_valid, s_ready;
  logic [7:0]       s_data;
  logic [31:0]      haddr_m, hwdata_m, csum;
  logic [1:0]       htrans_m, hresp_m;
  logic             hwrite_m, hsel_m, hready_m, busy, done, err;
  logic [2:0]       hsize_m, hburst_m;
  logic [3:0]       hprot_m;

  mem_boot_loader #(.LEN_W(LEN_W), .ADDR_ALIGN(2)) dut (
    .hclk(hclk), .hrst_b(hrst_b), .start(start), .cfg_base_addr(cfg_base_addr),
    .cfg_len_words(cfg_len_words), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .haddr_m(haddr_m), .htrans_m(htrans_m), .hwrite_m(hwrite_m), .hsize_m(hsize_m),
    .hburst_m(hburst_m), .hprot_m(hprot_m), .hsel_m(hsel_m), .hwdata_m(hwdata_m),
    .hready_m(hready_m), .hresp_m(hresp_m), .busy(busy), .done(done), .err(err), .csum(csum)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks, failures;
  int job_id;
  logic [7:0] job_bytes [0:63];
  int feed_cnt;
  int sl_mode, sl_err;

  // Byte source: presents the job's bytes in order with random gaps.
  int feed_job, feed_ptr, rdy_cnt, rdy_viol;
  initial begin
    s_valid = 1'b0; s_data = 8'h00;
    feed_job = 0; feed_ptr = 0; rdy_cnt = 0; rdy_viol = 0;
    forever begin
      @(negedge hclk);
      if (feed_job != job_id) begin
        feed_job = job_id; feed_ptr = 0; rdy_cnt = 0; rdy_viol = 0;
      end
      if (feed_ptr < feed_cnt && $urandom_range(0, 3) != 0) begin
        s_valid = 1'b1; s_data = job_bytes[feed_ptr];
      end else begin
        s_valid = 1'b0; s_data = 8'hEE;
      end
      if (s_valid && s_ready) feed_ptr++;
      if (s_ready) rdy_cnt++;
      if (s_ready && !busy) rdy_viol++;
    end
  end

  // AHB slave: drives hready/hresp, records completed writes, counts protocol violations.
  int sl_job, xfer_n, nonseq_n, viol_n, stall_a, stall_d;
  bit sl_dph, sl_rst_seen, prev_sa, prev_sd, sl_rdy;
  logic [1:0]  sl_resp;
  logic [31:0] d_addr, prev_addr, prev_wdata;
  logic [31:0] wr_addr[$], wr_data[$];
  logic [1:0]  wr_resp[$];
  initial begin
    hready_m = 1'b0; hresp_m = 2'b00;
    sl_job = 0; xfer_n = 0; nonseq_n = 0; viol_n = 0; stall_a = 0; stall_d = 0;
    sl_dph = 0; sl_rst_seen = 1; prev_sa = 0; prev_sd = 0;
    d_addr = 0; prev_addr = 0; prev_wdata = 0;
    forever begin
      @(negedge hclk);
      if (sl_job != job_id) begin
        sl_job = job_id; wr_addr.delete(); wr_data.delete(); wr_resp.delete();
        xfer_n = 0; nonseq_n = 0; viol_n = 0;
      end
      if (!hrst_b) begin
        sl_rst_seen = 1; sl_dph = 0; stall_a = 0; stall_d = 0; prev_sa = 0; prev_sd = 0;
        hready_m = 1'b0; hresp_m = 2'b00;
      end else begin
        sl_rdy = 1'b1;
        if (sl_mode == 1) sl_rdy = ($urandom_range(0, 2) != 0);
        else if (sl_mode == 2) begin
          if (htrans_m == 2'b10 && stall_a < 3) begin sl_rdy = 1'b0; stall_a++; end
          else if (sl_dph && stall_d < 3) begin sl_rdy = 1'b0; stall_d++; end
        end
        if (sl_rst_seen) begin sl_rdy = 1'b0; sl_rst_seen = 0; end
        sl_resp = (sl_dph && sl_rdy && xfer_n == sl_err) ? 2'b01 : 2'b00;
        hready_m = sl_rdy; hresp_m = sl_resp;
        if (prev_sa && (htrans_m != 2'b10 || haddr_m != prev_addr)) viol_n++;
        if (prev_sd && (htrans_m != 2'b00 || hwdata_m != prev_wdata)) viol_n++;
        if (hsel_m != (htrans_m == 2'b10)) viol_n++;
        if (htrans_m == 2'b10 && (!hwrite_m || hsize_m != 3'b010 || hburst_m != 3'b000 ||
                                  hprot_m != 4'b0011 || sl_dph)) viol_n++;
        if (htrans_m != 2'b10 && (htrans_m != 2'b00 || hwrite_m)) viol_n++;
        prev_sa = (htrans_m == 2'b10) && !sl_rdy; prev_addr = haddr_m;
        prev_sd = sl_dph && !sl_rdy; prev_wdata = hwdata_m;
        if (sl_dph && sl_rdy) begin
          wr_addr.push_back(d_addr); wr_data.push_back(hwdata_m); wr_resp.push_back(sl_resp);
          xfer_n++; sl_dph = 0; stall_d = 0;
        end
        if (htrans_m == 2'b10 && sl_rdy) begin
          sl_dph = 1; d_addr = haddr_m; nonseq_n++; stall_a = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic setup_job(input logic [31:0] base, input logic [LEN_W-1:0] len,
                           input int err_idx, input int mode, input int nbytes);
    @(posedge hclk); #1;
    job_id++;
    sl_mode = mode; sl_err = err_idx; feed_cnt = nbytes;
    cfg_base_addr = base; cfg_len_words = len;
    @(negedge hclk); start = 1'b1;
    @(negedge hclk); start = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] base, input logic [LEN_W-1:0] len, input int err_idx,
                         input int mode, input bit poke, output bit got_done, output bit got_err,
                         output int lat);
    bit fin;
    int cyc;
    setup_job(base, len, err_idx, mode, 4 * int'(len));
    check("err_clear_on_start", err, 1'b0);
    check("busy_after_start", busy, (len != 0));
    fin = 0; cyc = 0;
    while (!fin && cyc < 3000) begin
      if (done || err) fin = 1;
      else begin
        cyc++;
        start = poke && (cyc == 6);
        if (start) begin cfg_base_addr = 32'h0000_5000; cfg_len_words = '0; end
        @(negedge hclk);
      end
    end
    start = 1'b0;
    lat = cyc;
    check("job_finished", fin, 1'b1);
    got_done = done; got_err = err;
    check("busy_at_end", busy, 1'b0);
    @(negedge hclk);
    check("done_one_cycle", done, 1'b0);
    repeat (3) @(negedge hclk);
    #1;
    check("err_sticky", err, got_err);
  endtask

  // Word-level reference: image words land at consecutive word addresses until the first error.
  task automatic model_check(input logic [31:0] base, input logic [LEN_W-1:0] len,
                             input int err_idx, input bit got_done, input bit got_err);
    int n_exp;
    bit fails;
    logic [31:0] sum, ea, ed;
    fails = (err_idx >= 0) && (err_idx < int'(len));
    n_exp = fails ? err_idx + 1 : int'(len);
    sum = 32'd0;
    check("n_writes", wr_addr.size(), n_exp);
    check("n_nonseq", nonseq_n, n_exp);
    for (int i = 0; i < n_exp && i < wr_addr.size(); i++) begin
      ea = (base & 32'hFFFF_FFFC) + 32'(4 * i);
      ed = {job_bytes[4*i+3], job_bytes[4*i+2], job_bytes[4*i+1], job_bytes[4*i]};
      check("wr_addr", wr_addr[i], ea);
      check("wr_data", wr_data[i], ed);
      check("wr_resp", wr_resp[i], (fails && i == err_idx) ? 2'b01 : 2'b00);
      if (!(fails && i == err_idx)) sum = sum + ed;
    end
    check("done_seen", got_done, !fails);
    check("err_seen", got_err, fails);
`ifdef MEM_LOADER_CSUM_EN
    check("csum", csum, sum);
`else
    check("csum", csum, 32'd0);
`endif
    check("protocol_viol", viol_n, 0);
    check("s_ready_not_busy", rdy_viol, 0);
  endtask

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    int          err_idx;
    int          mode;
    bit          poke;
    logic [7:0]  b0;
    int          exp_n;
    logic [31:0] exp_last_addr;
    logic [31:0] exp_last_data;
    bit          exp_done;
  } vec_t;

  vec_t vt [6];

  initial begin
    bit gd, ge;
    int lat, k;
    logic [LEN_W-1:0] rl;
    int re, rm;
    logic [31:0] rb;
    checks = 0; failures = 0; job_id = 0; feed_cnt = 0; sl_mode = 0; sl_err = -1;
    hrst_b = 1'b0; start = 1'b0; cfg_base_addr = 32'd0; cfg_len_words = '0;
    for (int j = 0; j < 64; j++) job_bytes[j] = 8'h00;

    vt[0] = '{32'h0000_0100, 16'd2, -1, 0, 1'b0, 8'h11, 2, 32'h0000_0104, 32'h8877_6655, 1'b1};
    vt[1] = '{32'hFFFF_FFFC, 16'd2, -1, 1, 1'b1, 8'h01, 2, 32'h0000_0000, 32'h7867_5645, 1'b1};
    vt[2] = '{32'h0000_0203, 16'd3,  1, 0, 1'b0, 8'h10, 2, 32'h0000_0204, 32'h8776_6554, 1'b0};
    vt[3] = '{32'h0000_0000, 16'd1,  0, 2, 1'b0, 8'hA0, 1, 32'h0000_0000, 32'hD3C2_B1A0, 1'b0};
    vt[4] = '{32'h0000_1000, 16'd0, -1, 0, 1'b0, 8'h00, 0, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[5] = '{32'h0000_0040, 16'd2, -1, 2, 1'b0, 8'h11, 2, 32'h0000_0044, 32'h8877_6655, 1'b1};

    #12;
    check("rst_htrans", htrans_m, 2'b00);
    check("rst_hsize", hsize_m, 3'b010);
    check("rst_hburst", hburst_m, 3'b000);
    check("rst_hprot", hprot_m, 4'b0011);
    check("rst_haddr", haddr_m, 32'd0);
    check("rst_hwdata", hwdata_m, 32'd0);
    check("rst_ctrl", {s_ready, hwrite_m, hsel_m, busy, done, err}, 6'b0);
    check("rst_csum", csum, 32'd0);
    @(negedge hclk); hrst_b = 1'b1;

    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < 64; j++) job_bytes[j] = vt[t].b0 + 8'(17 * j);
      run_job(vt[t].base, vt[t].len, vt[t].err_idx, vt[t].mode, vt[t].poke, gd, ge, lat);
      model_check(vt[t].base, vt[t].len, vt[t].err_idx, gd, ge);
      check("tbl_n", wr_addr.size(), vt[t].exp_n);
      check("tbl_done", gd, vt[t].exp_done);
      if (vt[t].exp_n > 0 && wr_addr.size() > 0) begin
        check("tbl_last_addr", wr_addr[wr_addr.size()-1], vt[t].exp_last_addr);
        check("tbl_last_data", wr_data[wr_data.size()-1], vt[t].exp_last_data);
      end
      if (vt[t].len == 0) begin
        check("len0_latency", lat, 0);
        check("len0_no_s_ready", rdy_cnt, 0);
      end
    end

    // Async reset while an address phase is stalled on the bus.
    for (int j = 0; j < 8; j++) job_bytes[j] = 8'(8'h30 + j);
    setup_job(32'h0000_0700, 16'd2, -1, 2, 8);
    k = 0;
    while (htrans_m != 2'b10 && k < 200) begin @(negedge hclk); k++; end
    check("reach_addr_phase", htrans_m, 2'b10);
    check("addr_before_rst", haddr_m, 32'h0000_0700);
    #2 hrst_b = 1'b0;
    #1;
    check("async_rst_htrans", htrans_m, 2'b00);
    check("async_rst_ctrl", {hsel_m, hwrite_m, busy, s_ready}, 4'b0);
    @(negedge hclk); @(negedge hclk); hrst_b = 1'b1;

    // Async reset after two bytes of a word; the restart must use only new bytes.
    job_bytes[0] = 8'hDE; job_bytes[1] = 8'hAD;
    setup_job(32'h0000_0300, 16'd1, -1, 0, 2);
    k = 0;
    do begin @(negedge hclk); #1; k++; end while (feed_ptr < 2 && k < 200);
    check("two_bytes_fed", feed_ptr, 2);
    @(negedge hclk);
    #2 hrst_b = 1'b0;
    #1;
    check("partial_rst_htrans", htrans_m, 2'b00);
    check("partial_rst_ctrl", {s_ready, busy}, 2'b00);
    @(negedge hclk); hrst_b = 1'b1;
    for (int j = 0; j < 4; j++) job_bytes[j] = 8'(j + 1);
    run_job(32'h0000_0300, 16'd1, -1, 0, 1'b0, gd, ge, lat);
    model_check(32'h0000_0300, 16'd1, -1, gd, ge);
    if (wr_data.size() > 0) check("restart_word", wr_data[0], 32'h0403_0201);

    // Randomized jobs against the reference model.
    for (int r = 0; r < 12; r++) begin
      rl = LEN_W'($urandom_range(1, 4));
      re = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(rl) - 1)) : -1;
      rm = $urandom_range(0, 2);
      rb = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      for (int j = 0; j < 64; j++) job_bytes[j] = 8'($urandom);
      run_job(rb, rl, re, rm, ($urandom_range(0, 1) == 1), gd, ge, lat);
      model_check(rb, rl, re, gd, ge);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
